// File: rtl/libar_pkg.sv
// Shared types and defaults for the LIBAR key loader.
// The CHK state exists only when KEY_CHK_EN is defined.
package libar_pkg;

  localparam int unsigned KeyWDefault   = 32;
  localparam int unsigned ChunkWDefault = 8;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
`ifdef KEY_CHK_EN
    StChk,
`endif
    StArmed,
    StErr
  } ld_state_t;

  // Width of a counter indexing 0..beats-1, never narrower than one bit.
  function automatic int unsigned cnt_width(int unsigned beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/libar_key_loader_if.sv
// Valid/ready chunk stream feeding the key loader; master = key source, slave = loader.
interface libar_key_loader_if #(
  parameter int unsigned CHUNK_W = libar_pkg::ChunkWDefault
) ();
  logic               valid;
  logic               ready;
  logic [CHUNK_W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/libar_key_loader.sv
// Streams a key in CHUNK_W beats into a shadow register and commits it to key_out_o whole.
// Optional feature macro KEY_CHK_EN: a trailing XOR checksum beat gates the commit.
module libar_key_loader
  import libar_pkg::*;
#(
  parameter int unsigned KEY_W   = KeyWDefault,
  parameter int unsigned CHUNK_W = ChunkWDefault
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start_i,
  libar_key_loader_if.slave   s_if,
  output logic [KEY_W-1:0]    key_out_o,
  output logic                key_valid_o,
  output logic                busy_o,
  output logic                err_o
);

  localparam int unsigned Beats = KEY_W / CHUNK_W;
  localparam int unsigned CntW  = cnt_width(Beats);

  ld_state_t        state_q, state_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [KEY_W-1:0] shadow_q, shadow_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             ready;
  logic             beat, last_beat, rearm, in_load;

  assign beat      = s_if.valid && ready;
  assign in_load   = (state_q == StLoad);
  assign last_beat = (cnt_q == CntW'(Beats - 1));
  assign rearm     = start_i && ((state_q == StArmed) || (state_q == StErr));

`ifdef KEY_CHK_EN
  logic [CHUNK_W-1:0] xor_q, xor_d;
  logic               match;

  assign match = (s_if.data == xor_q);

  always_comb begin
    xor_d = xor_q;
    if (rearm) begin
      xor_d = '0;
    end else if (in_load && beat) begin
      xor_d = xor_q ^ s_if.data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xor_q <= '0;
    end else begin
      xor_q <= xor_d;
    end
  end
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; start is ignored while a load is in flight.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start_i) state_d = StLoad;
      end
      StLoad: begin
`ifdef KEY_CHK_EN
        if (beat && last_beat) state_d = StChk;
`else
        if (beat && last_beat) state_d = StArmed;
`endif
      end
`ifdef KEY_CHK_EN
      StChk: begin
        if (beat) state_d = match ? StArmed : StErr;
      end
`endif
      StArmed, StErr: begin
        if (start_i) state_d = StLoad;
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
`ifdef KEY_CHK_EN
    ready  = (state_q == StLoad) || (state_q == StChk);
    err_o  = (state_q == StErr);
`else
    ready  = (state_q == StLoad);
    err_o  = 1'b0;
`endif
    busy_o      = ready;
    key_valid_o = (state_q == StArmed);
    key_out_o   = key_q;
  end

  assign s_if.ready = ready;

  // Datapath: beat counter, shadow register, committed key.
  always_comb begin
    cnt_d    = cnt_q;
    shadow_d = shadow_q;
    key_d    = key_q;
    if (rearm) begin
      cnt_d    = '0;
      shadow_d = '0;
      key_d    = '0;
    end else if (in_load && beat) begin
      shadow_d[32'(cnt_q) * CHUNK_W +: CHUNK_W] = s_if.data;
      cnt_d = last_beat ? '0 : cnt_q + CntW'(1);
`ifndef KEY_CHK_EN
      // Commit includes the beat landing on this same edge.
      if (last_beat) key_d = shadow_d;
`endif
    end
`ifdef KEY_CHK_EN
    else if ((state_q == StChk) && beat && match) begin
      key_d = shadow_q;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      shadow_q <= '0;
      key_q    <= '0;
    end else begin
      cnt_q    <= cnt_d;
      shadow_q <= shadow_d;
      key_q    <= key_d;
    end
  end

endmodule

// File: tb/tb_libar_key_loader.sv
// Directed bench for libar_key_loader with a queue-based reference model checked every cycle.
// Honours KEY_CHK_EN the same way as the design.
module tb_libar_key_loader;

  localparam int unsigned KeyW   = 32;
  localparam int unsigned ChunkW = 8;
  localparam int unsigned Beats  = KeyW / ChunkW;

  logic            clk    = 1'b0;
  logic            rst_n  = 1'b1;
  logic            start  = 1'b0;
  logic [KeyW-1:0] key_out;
  logic            key_valid, busy, err;
  int              n_checks = 0;
  int              n_errors = 0;
  bit              cmp_en   = 1'b0;

  libar_key_loader_if #(.CHUNK_W(ChunkW)) s_if ();

  libar_key_loader #(.KEY_W(KeyW), .CHUNK_W(ChunkW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start_i     (start),
    .s_if        (s_if),
    .key_out_o   (key_out),
    .key_valid_o (key_valid),
    .busy_o      (busy),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects accepted beats and decides the outcome once the load is complete.
  bit              m_loading = 1'b0;
  bit              m_armed   = 1'b0;
  bit              m_err     = 1'b0;
  logic [KeyW-1:0] m_key     = '0;
  logic [7:0]      m_q[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_loading = 1'b0;
      m_armed   = 1'b0;
      m_err     = 1'b0;
      m_key     = '0;
      m_q.delete();
    end else if (m_loading && s_if.valid) begin
      logic [KeyW-1:0] k;
      logic [7:0]      x;
      m_q.push_back(s_if.data);
      k = '0;
      x = '0;
      for (int i = 0; i < m_q.size() && i < Beats; i++) begin
        k = k | (KeyW'(m_q[i]) << (ChunkW * i));
        x = x ^ m_q[i];
      end
`ifdef KEY_CHK_EN
      if (m_q.size() == Beats + 1) begin
        m_loading = 1'b0;
        if (m_q[Beats] == x) begin
          m_armed = 1'b1;
          m_key   = k;
        end else begin
          m_err = 1'b1;
        end
        m_q.delete();
      end
`else
      if (m_q.size() == Beats) begin
        m_loading = 1'b0;
        m_armed   = 1'b1;
        m_key     = k;
        m_q.delete();
      end
`endif
    end else if (start && !m_loading) begin
      m_loading = 1'b1;
      m_armed   = 1'b0;
      m_err     = 1'b0;
      m_key     = '0;
      m_q.delete();
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_key_out",   key_out,          m_key);
      chk("cyc_key_valid", 32'(key_valid),   32'(m_armed));
      chk("cyc_busy",      32'(busy),        32'(m_loading));
      chk("cyc_s_ready",   32'(s_if.ready),  32'(m_loading));
      chk("cyc_err",       32'(err),         32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic beat(input logic [7:0] d);
    s_if.valid = 1'b1;
    s_if.data  = d;
    tick();
    s_if.valid = 1'b0;
  endtask

  // Sends k LSB chunk first with `gap` idle cycles before each beat; csum_flip corrupts the checksum.
  task automatic send_key(input logic [31:0] k, input int gap, input logic [7:0] csum_flip);
    logic [7:0] x;
    int         total;
    x = '0;
`ifdef KEY_CHK_EN
    total = Beats + 1;
`else
    total = Beats;
`endif
    for (int i = 0; i < total; i++) begin
      logic [7:0] d;
      d = (i < Beats) ? k[ChunkW*i +: ChunkW] : (x ^ csum_flip);
      x = x ^ d;
      for (int g = 0; g < gap; g++) tick();
      if (i == total - 1) chk("key_hidden_before_last", key_out, 32'h0);
      beat(d);
    end
  endtask

  initial begin
    s_if.valid = 1'b0;
    s_if.data  = '0;
    #1 rst_n = 1'b0;
    #1 cmp_en = 1'b1;
    tick();
    tick();
    chk("reset_key_out", key_out, 32'h0);
    chk("reset_key_valid", 32'(key_valid), 32'h0);
    chk("reset_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    tick();

    // 1: back-to-back load
    pulse_start();
    chk("t1_busy", 32'(busy), 32'h1);
    send_key(32'hDEADBEEF, 0, 8'h00);
    chk("t1_key_out", key_out, 32'hDEADBEEF);
    chk("t1_key_valid", 32'(key_valid), 32'h1);
    chk("t1_err", 32'(err), 32'h0);

    // s_valid while armed is ignored
    beat(8'h55);
    tick();
    chk("armed_ignore_valid", key_out, 32'hDEADBEEF);

    // 2: same key with gaps of 0..3 cycles
    for (int g = 0; g < 4; g++) begin
      pulse_start();
      send_key(32'hDEADBEEF, g, 8'h00);
      chk("t2_key_out_gap", key_out, 32'hDEADBEEF);
      chk("t2_key_valid_gap", 32'(key_valid), 32'h1);
    end

`ifdef KEY_CHK_EN
    // 3: corrupted checksum 0x23 instead of 0x22
    pulse_start();
    send_key(32'hDEADBEEF, 0, 8'h01);
    chk("t3_err", 32'(err), 32'h1);
    chk("t3_key_valid", 32'(key_valid), 32'h0);
    chk("t3_key_out", key_out, 32'h0);
    pulse_start();
    chk("t3_err_cleared", 32'(err), 32'h0);
    send_key(32'hDEADBEEF, 1, 8'h00);
    chk("t3_good_key", key_out, 32'hDEADBEEF);
`endif

    // 4: reset after two beats, then a fresh load
    pulse_start();
    beat(8'h99);
    beat(8'h88);
    rst_n = 1'b0;
    tick();
    chk("t4_reset_busy", 32'(busy), 32'h0);
    chk("t4_reset_key", key_out, 32'h0);
    rst_n = 1'b1;
    tick();
    pulse_start();
    send_key(32'h44332211, 0, 8'h00);
    chk("t4_key_out", key_out, 32'h44332211);

    // 5: restart from ARMED clears the key next cycle
    pulse_start();
    chk("t5_key_cleared", key_out, 32'h0);
    chk("t5_valid_cleared", 32'(key_valid), 32'h0);
    send_key(32'h04030201, 0, 8'h00);
    chk("t5_key_out", key_out, 32'h04030201);

    // 6: start during LOAD is ignored, also when coincident with a beat
    pulse_start();
    beat(8'hA1);
    pulse_start();
    chk("t6_still_busy", 32'(busy), 32'h1);
    start = 1'b1;
    beat(8'hB2);
    start = 1'b0;
    beat(8'hC3);
    beat(8'hD4);
`ifdef KEY_CHK_EN
    beat(8'h04);
`endif
    chk("t6_key_out", key_out, 32'hD4C3B2A1);
    chk("t6_key_valid", 32'(key_valid), 32'h1);

    tick();
    tick();
    cmp_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
